// File: rtl/dmmu_stage.sv
// Data-side address-translation stage: direct address, DMW window or TLB lookup,
// with a one-entry valid/ready response buffer and a saturating refill-miss counter.
module dmmu_stage #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_va,
   input  logic              req_store,
   input  logic              crmd_da,
   input  logic              crmd_pg,
   input  logic [1:0]        crmd_plv,
   input  logic [1:0]        crmd_datm,
   input  logic [31:0]       dmw0,
   input  logic [31:0]       dmw1,
   input  logic [9:0]        csr_asid,
   output logic [18:0]       s1_vppn,
   output logic              s1_va_bit12,
   output logic [9:0]        s1_asid,
   input  logic              s1_found,
   input  logic              s1_d,
   input  logic              s1_v,
   input  logic [5:0]        s1_ps,
   input  logic [19:0]       s1_ppn,
   input  logic [1:0]        s1_plv,
   input  logic [1:0]        s1_mat,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_pa,
   output logic [1:0]        rsp_mat,
   output logic              rsp_ex,
   output logic [5:0]        rsp_ecode,
   output logic [CNT_W-1:0]  miss_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        dmw0_hit;
   logic        dmw1_hit;
   logic [31:0] x_pa;
   logic [1:0]  x_mat;
   logic        x_ex;
   logic [5:0]  x_ecode;
   logic        x_tlbr;

   // A window only matches at PLV0 or PLV3, each gated by its own enable bit.
   function automatic logic dmw_hit(input logic [31:0] dmw,
                                    input logic [1:0]  plv,
                                    input logic [2:0]  vseg);
      logic plv_en;
      case (plv)
         2'd0:    plv_en = dmw[0];
         2'd3:    plv_en = dmw[3];
         default: plv_en = 1'b0;
      endcase
      return plv_en && (dmw[31:29] == vseg);
   endfunction

   assign s1_vppn     = req_va[31:13];
   assign s1_va_bit12 = req_va[12];
   assign s1_asid     = csr_asid;

   assign dmw0_hit  = dmw_hit(dmw0, crmd_plv, req_va[31:29]);
   assign dmw1_hit  = dmw_hit(dmw1, crmd_plv, req_va[31:29]);
   assign rsp_valid = (state == FULL);
   // Reset empties the buffer, so the stage reports ready while reset is held.
   assign req_ready = !flush && (reset || !rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready && !reset;

   // Translation of the current request; exceptions report the VA and MAT 0.
   always_comb begin
      x_pa    = req_va;
      x_mat   = 2'b00;
      x_ex    = 1'b0;
      x_ecode = 6'h00;
      x_tlbr  = 1'b0;
      if (crmd_da) begin
         x_mat = crmd_datm;
      end else if (crmd_pg && dmw0_hit) begin
         x_pa  = {dmw0[27:25], req_va[28:0]};
         x_mat = dmw0[5:4];
      end else if (crmd_pg && dmw1_hit) begin
         x_pa  = {dmw1[27:25], req_va[28:0]};
         x_mat = dmw1[5:4];
      end else if (!s1_found) begin
         x_ex    = 1'b1;
         x_ecode = ECODE_TLBR;
         x_tlbr  = 1'b1;
      end else if (!s1_v) begin
         x_ex    = 1'b1;
         x_ecode = req_store ? ECODE_PIS : ECODE_PIL;
      end else if (crmd_plv > s1_plv) begin
         x_ex    = 1'b1;
         x_ecode = ECODE_PPI;
      end else if (req_store && !s1_d) begin
         x_ex    = 1'b1;
         x_ecode = ECODE_PME;
      end else begin
         x_mat = s1_mat;
         if (s1_ps == 6'd12) begin
            x_pa = {s1_ppn, req_va[11:0]};
         end else begin
            x_pa = {s1_ppn[19:10], req_va[21:0]};
         end
      end
   end

   // Buffer next state; flush overrides every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = FULL;
            end else begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (accept) begin
               state_nxt = FULL;
            end else if (rsp_ready) begin
               state_nxt = EMPTY;
            end else begin
               state_nxt = FULL;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         state_nxt = state_nxt;
      end
   end

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Response payload is captured only on accept, so later CSR/TLB changes cannot disturb it.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_pa    <= 32'h0000_0000;
         rsp_mat   <= 2'b00;
         rsp_ex    <= 1'b0;
         rsp_ecode <= 6'h00;
      end else if (accept) begin
         rsp_pa    <= x_pa;
         rsp_mat   <= x_mat;
         rsp_ex    <= x_ex;
         rsp_ecode <= x_ecode;
      end
   end

   // Saturating count of accepted requests that ended in a TLB refill.
   always_ff @(posedge clk) begin
      if (reset) begin
         miss_cnt <= {CNT_W{1'b0}};
      end else if (accept && x_tlbr && (miss_cnt != {CNT_W{1'b1}})) begin
         miss_cnt <= miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: doc/dmmu_stage.md
# dmmu_stage

Data-side address-translation stage between execute and memory access. It takes a virtual load/store address and resolves it by one of three methods: direct-address mode, a direct-mapped window (DMW), or a lookup on the TLB's search port 1. It registers the physical address, memory attribute and any translation exception in a one-entry output buffer under valid/ready handshake. It also keeps a saturating count of TLB refill misses for performance debug.

## Interface
Parameters:
- CNT_W, default 16, width of the refill-miss counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush; kills the buffered response.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept a request.
- req_va  in  32  virtual address.
- req_store  in  1  1 = store, 0 = load.
- crmd_da, crmd_pg  in  1 each  CSR.CRMD translation-mode bits.
- crmd_plv  in  2  current privilege level.
- crmd_datm  in  2  MAT used in direct-address mode.
- dmw0, dmw1  in  32 each  CSR.DMW0/1 (bit0 PLV0 enable, bit3 PLV3 enable, [5:4] MAT, [27:25] PSEG, [31:29] VSEG).
- csr_asid  in  10  current ASID.
- s1_vppn  out  19  TLB search VPPN = req_va[31:13].
- s1_va_bit12  out  1  = req_va[12].
- s1_asid  out  10  = csr_asid.
- s1_found, s1_d, s1_v  in  1 each  TLB search results.
- s1_ps  in  6  page size, 12 or 22.
- s1_ppn  in  20  physical page number.
- s1_plv, s1_mat  in  2 each  page privilege level and page MAT.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes response.
- rsp_pa  out  32  physical address.
- rsp_mat  out  2  memory attribute.
- rsp_ex  out  1  translation exception.
- rsp_ecode  out  6  exception code, valid when rsp_ex = 1.
- miss_cnt  out  CNT_W  TLB refill misses seen since reset.

## Operation
- The TLB search is combinational. The search-port outputs are driven from req_va every cycle, so a request is translated in the same cycle it is accepted.
- Accept condition: `req_valid && req_ready`. Definition: `req_ready = !flush && (!rsp_valid || rsp_ready)`.
- Translation is resolved in priority order:
  1. **Direct address** (crmd_da = 1): pa = va; mat = crmd_datm; no exception.
  2. **DMW** (crmd_pg = 1): DMWn hits when dmwN[crmd_plv==0 ? 0 : crmd_plv==3 ? 3 : none] is set and va[31:29] == dmwN[31:29]. DMW0 wins over DMW1. On a hit: pa = {dmwN[27:25], va[28:0]}; mat = dmwN[5:4]; no exception.
  3. **TLB**: exceptions are checked in this order, first match wins:
     - !s1_found → ecode 0x3F (TLBR).
     - !s1_v → 0x01 (PIL) for a load, 0x02 (PIS) for a store.
     - crmd_plv > s1_plv → 0x07 (PPI).
     - req_store && !s1_d → 0x04 (PME).
     - Otherwise no exception. When s1_ps == 12: pa = {s1_ppn, va[11:0]}. Otherwise: pa = {s1_ppn[19:10], va[21:0]}. mat = s1_mat.
- On any exception: rsp_pa = va and rsp_mat = 0.
- miss_cnt increments by 1 on each accepted request that ends in TLBR, and saturates at all-ones.
- Two-state buffer:
  - **EMPTY → FULL** on accept.
  - **FULL → EMPTY** on rsp_ready with no new accept.
  - **FULL → FULL** on rsp_ready with an accept; the buffer reloads in the same cycle, giving back-to-back throughput of 1 per cycle.
  - flush in any state → EMPTY.

## Timing
- Latency: a request accepted in cycle N appears with rsp_valid = 1 in cycle N+1.
- Reset values: rsp_valid = 0, rsp_pa = 0, rsp_mat = 0, rsp_ex = 0, rsp_ecode = 0, miss_cnt = 0. req_ready = 1 during reset unless flush is high.
- Reset mid-operation: any buffered response is discarded; miss_cnt clears.
- rsp_* outputs stay stable while rsp_valid && !rsp_ready.
- flush has priority over rsp_ready and over accept. With flush = 1 no request is accepted and miss_cnt does not change.
- CSR inputs and TLB results are sampled only in the accept cycle. A later change to them, or a TLB write/invalidation, does not alter a response already buffered.

## Test plan
- DA mode: crmd_da=1, crmd_datm=1, va=0x1234_5678 → next cycle rsp_pa=0x1234_5678, rsp_mat=1, rsp_ex=0.
- DMW hit: crmd_pg=1, plv=0, dmw0=0x8000_0011, va=0x8000_1000 → rsp_pa=0x0000_1000, mat=1. Same case with plv=3 → misses DMW0 and goes to TLB.
- TLB 4 KB hit: s1_found=1, v=1, d=1, ps=12, ppn=0x00ABC, va=0x0040_0123 → rsp_pa=0x00AB_C123. Same hit with store and d=0 → ex=1, ecode=0x04.
- TLB miss: three accepted loads with s1_found=0 → ecode=0x3F on each, miss_cnt=3. Preload miss_cnt to saturation → stays 0xFFFF.
- Backpressure and flush: hold rsp_ready=0 with rsp_valid=1 → req_ready=0 and rsp_* stable. Assert flush for one cycle → rsp_valid=0 the next cycle and the request offered in the flush cycle is not accepted.
- Throughput: 4 back-to-back requests with rsp_ready=1 → 4 responses in 4 consecutive cycles, in order.
